// File: rtl/capture6_fifo.sv
// Edge-triggered capture of a 6-bit gated bus into a DEPTH-entry FIFO; one-cycle capture-to-head latency.
// Backpressure via ready_i; a capture while full with no pop is dropped and latched in sticky overflow_o.
module capture6_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [5:0]                 data_i,
   input  logic                       en_i,
   input  logic                       clr_i,
   input  logic                       ready_i,
   output logic [5:0]                 data_o,
   output logic                       valid_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       overflow_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [5:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          en_q;

   logic cap, pop, push, full;

   assign full = (count_q == DEPTH_C);
   assign cap  = en_i & ~en_q;
   assign pop  = (count_q != '0) & ready_i;
   // A full buffer still takes a capture when the head leaves on the same edge.
   assign push = cap & (~full | pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
         if (cap && full && !pop) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         en_q     <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         en_q     <= en_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is left unreset; count_q gates every read of it.
   always_ff @(posedge clk_i) begin
      if (push && !clr_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign valid_o    = (count_q != '0);
   assign full_o     = full;
   assign count_o    = count_q;
   assign overflow_o = ovf_q;
   assign data_o     = valid_o ? mem_q[rd_ptr_q] : 6'b0;

endmodule

// File: tb/tb_capture6_fifo.sv
// Directed bench for capture6_fifo (DEPTH=4) with immediate-assertion checks.
module tb_capture6_fifo;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [5:0] data_i;
   logic       en_i;
   logic       clr_i;
   logic       ready_i;
   logic [5:0] data_o;
   logic       valid_o;
   logic [2:0] count_o;
   logic       full_o;
   logic       overflow_o;

   int n_chk  = 0;
   int n_fail = 0;

   capture6_fifo #(.DEPTH(4)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .data_i     (data_i),
      .en_i       (en_i),
      .clr_i      (clr_i),
      .ready_i    (ready_i),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .count_o    (count_o),
      .full_o     (full_o),
      .overflow_o (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pulse(input logic [5:0] v);
      en_i = 1'b1; data_i = v;
      tick();
      en_i = 1'b0; data_i = 6'h00;
      tick();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_count"}, 32'(count_o), 0);
      chk({tag, "_valid"}, 32'(valid_o), 0);
      chk({tag, "_full"},  32'(full_o), 0);
      chk({tag, "_ovf"},   32'(overflow_o), 0);
      chk({tag, "_data"},  32'(data_o), 0);
   endtask

   initial begin
      rst_ni = 1'b0; data_i = 6'h00; en_i = 1'b0; clr_i = 1'b0; ready_i = 1'b0;
      #1;
      chk_zero("reset");

      // en_i already high when reset releases: first edge is a capture
      en_i = 1'b1; data_i = 6'h0C;
      tick();
      rst_ni = 1'b1;
      tick();
      chk("first_cap_valid", 32'(valid_o), 1);
      chk("first_cap_data",  32'(data_o), 32'h0C);
      en_i = 1'b0; data_i = 6'h00; ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      chk("first_cap_drain", 32'(valid_o), 0);

      // single capture
      en_i = 1'b1; data_i = 6'h2A;
      tick();
      en_i = 1'b0; data_i = 6'h00;
      chk("single_valid", 32'(valid_o), 1);
      chk("single_data",  32'(data_o), 32'h2A);
      chk("single_count", 32'(count_o), 1);
      tick();
      chk("single_hold", 32'(data_o), 32'h2A);
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      chk("single_pop_valid", 32'(valid_o), 0);
      chk("single_pop_data",  32'(data_o), 0);

      // level-high enable captures once
      en_i = 1'b1; data_i = 6'h15;
      repeat (5) tick();
      en_i = 1'b0; data_i = 6'h00;
      tick();
      chk("level_count", 32'(count_o), 1);
      chk("level_data",  32'(data_o), 32'h15);
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      chk("level_drain", 32'(count_o), 0);

      // fill and overflow
      for (int i = 1; i <= 4; i++) pulse(6'(i));
      chk("fill_full", 32'(full_o), 1);
      chk("fill_ovf_pre", 32'(overflow_o), 0);
      pulse(6'h05);
      chk("ovf_count", 32'(count_o), 4);
      chk("ovf_full",  32'(full_o), 1);
      chk("ovf_flag",  32'(overflow_o), 1);
      ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("ovf_drain_data", 32'(data_o), 32'(i));
         tick();
      end
      ready_i = 1'b0;
      chk("ovf_drain_empty", 32'(valid_o), 0);
      chk("ovf_sticky", 32'(overflow_o), 1);
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      chk("clr_ovf", 32'(overflow_o), 0);

      // full with simultaneous push and pop
      for (int i = 0; i < 4; i++) pulse(6'h11 + 6'(i));
      en_i = 1'b1; data_i = 6'h3F; ready_i = 1'b1;
      tick();
      en_i = 1'b0; data_i = 6'h00;
      chk("fullpp_count", 32'(count_o), 4);
      chk("fullpp_ovf",   32'(overflow_o), 0);
      chk("fullpp_d0", 32'(data_o), 32'h12); tick();
      chk("fullpp_d1", 32'(data_o), 32'h13); tick();
      chk("fullpp_d2", 32'(data_o), 32'h14); tick();
      chk("fullpp_d3", 32'(data_o), 32'h3F); tick();
      chk("fullpp_empty", 32'(count_o), 0);

      // wrap-around with consumer always ready
      for (int i = 0; i < 10; i++) begin
         en_i = 1'b1; data_i = 6'(i);
         tick();
         en_i = 1'b0; data_i = 6'h00;
         chk("wrap_valid", 32'(valid_o), 1);
         chk("wrap_data",  32'(data_o), 32'(i));
         chk("wrap_count", 32'(count_o), 1);
         tick();
         chk("wrap_popped", 32'(count_o), 0);
      end
      ready_i = 1'b0;

      // asynchronous reset mid-operation
      for (int i = 1; i <= 5; i++) pulse(6'(i));
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      chk("pre_rst_count", 32'(count_o), 3);
      chk("pre_rst_ovf",   32'(overflow_o), 1);
      #2 rst_ni = 1'b0;
      #1;
      chk_zero("async_rst");
      tick();
      rst_ni = 1'b1;
      pulse(6'h2B);
      chk("post_rst_data",  32'(data_o), 32'h2B);
      chk("post_rst_count", 32'(count_o), 1);
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;

      // synchronous clear, also racing a capture event
      for (int i = 1; i <= 5; i++) pulse(6'(i));
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      chk("pre_clr_count", 32'(count_o), 3);
      chk("pre_clr_ovf",   32'(overflow_o), 1);
      clr_i = 1'b1; en_i = 1'b1; data_i = 6'h07;
      tick();
      clr_i = 1'b0;
      chk_zero("clr");
      tick();
      chk("clr_en_level", 32'(count_o), 0);
      en_i = 1'b0; data_i = 6'h00;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/capture6_fifo.md
CAPTURE6_FIFO -- requirements
Module: capture6_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of 6-bit entries buffered (power of two, 2..16).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have port data_i  input  6  gated data bus from the 6-bit gated-bus writer; reads zero while en_i low.
REQ-005 SHALL have port en_i  input  1  writer enable; a word is offered on each en_i rising edge.
REQ-006 SHALL have port clr_i  input  1  synchronous flush of buffer and overflow flag.
REQ-007 SHALL have port ready_i  input  1  consumer ready for the head word.
REQ-008 SHALL have port data_o  output  6  head word; 6'b0 when valid_o low.
REQ-009 SHALL have port valid_o  output  1  head word present.
REQ-010 SHALL have port count_o  output  $clog2(DEPTH)+1  number of stored words.
REQ-011 SHALL have port full_o  output  1  count_o == DEPTH.
REQ-012 SHALL have port overflow_o  output  1  sticky; a capture was dropped.

Function
REQ-013 SHALL register en_i into en_q each cycle; capture event = en_i & ~en_q.
REQ-014 SHALL sample data_i at the capture-event clock edge; level-high en_i after the first cycle SHALL NOT cause further captures.
REQ-015 SHALL treat en_i high in the first cycle after reset release as a capture event (en_q resets to 0).
REQ-016 SHALL pop the head on a clock edge where valid_o & ready_i.
REQ-017 SHALL push the captured word on a capture event when count_o < DEPTH.
REQ-018 SHALL, on a capture event while full, accept the push if a pop occurs the same edge (count unchanged); otherwise drop it, keep contents, set overflow_o.
REQ-019 SHALL, on simultaneous push and pop when not full, keep count_o unchanged and order FIFO.
REQ-020 SHALL never pop when empty; ready_i with valid_o low has no effect.
REQ-021 SHALL give one-cycle latency: word captured at edge N is on data_o with valid_o high immediately after edge N when buffer was empty.
REQ-022 SHALL keep data_o/valid_o stable while valid_o & ~ready_i.
REQ-023 SHALL wrap read/write pointers modulo DEPTH with no lost or duplicated words.
REQ-024 SHALL give clr_i priority over push and pop: count_o=0, pointers=0, overflow_o=0, valid_o=0 after the edge; en_q still updates.
REQ-025 SHALL derive valid_o = (count_o != 0), full_o = (count_o == DEPTH), data_o = valid_o ? head : 6'b0.

Reset
REQ-026 SHALL, while rst_ni low, force count_o=0, valid_o=0, full_o=0, overflow_o=0, data_o=6'b0, en_q=0, pointers=0, immediately and independent of clk_i.
REQ-027 SHALL discard buffered words on reset mid-operation; storage array contents need not be reset.
REQ-028 SHALL resume normal capture on the first rising edge after rst_ni deasserts.

Verification
REQ-029 Single capture: ready_i=0, en_i pulse 1 cycle with data_i=6'h2A -> next cycle valid_o=1, data_o=6'h2A, count_o=1; ready_i=1 one cycle -> valid_o=0, data_o=0.
REQ-030 Level enable: en_i held high 5 cycles, data_i=6'h15 -> exactly one word stored, count_o=1.
REQ-031 Fill/overflow (DEPTH=4): 5 en_i pulses 6'h01..6'h05, ready_i=0 -> full_o=1, count_o=4, overflow_o=1; drain reads 01,02,03,04.
REQ-032 Full with simultaneous pop: full, en_i pulse 6'h3F with ready_i=1 same edge -> count_o stays 4, overflow_o stays 0, 6'h3F read last.
REQ-033 Wrap-around: 10 push/pop pairs 6'h00..6'h09 with ready_i=1 -> outputs in order, count_o never exceeds 1.
REQ-034 Reset/clear: with count_o=3 and overflow_o=1, assert rst_ni=0 mid-cycle -> all outputs zero before next edge; repeat with clr_i=1 one cycle -> same zeros after edge.
